// File: rtl/dmac_channel_engine_if.sv
// AHB master-side bus bundle between the channel engine and the bus fabric.
// Pure wiring, no latency.
// Backpressure is carried by m_HREADY (slave wait states) and m_HRESP.
interface dmac_channel_engine_if;
    logic        m_HBUSREQ;
    logic [31:0] m_HADDR;
    logic [1:0]  m_HTRANS;
    logic        m_HWRITE;
    logic [2:0]  m_HSIZE;
    logic [2:0]  m_HBURST;
    logic [31:0] m_HWDATA;
    logic        m_HREADY;
    logic [1:0]  m_HRESP;
    logic [31:0] m_HRDATA;

    modport master (
        output m_HBUSREQ, m_HADDR, m_HTRANS, m_HWRITE, m_HSIZE, m_HBURST, m_HWDATA,
        input  m_HREADY, m_HRESP, m_HRDATA
    );

    modport slave (
        input  m_HBUSREQ, m_HADDR, m_HTRANS, m_HWRITE, m_HSIZE, m_HBURST, m_HWDATA,
        output m_HREADY, m_HRESP, m_HRDATA
    );
endinterface

// File: rtl/dmac_channel_engine.sv
// Single-channel DMA engine: read burst into a 4-word buffer, then write it out.
// Latency: zero-wait SINGLE copy takes 7 cycles from LOAD to DONE; INCR4 takes 10 cycles per burst pair.
// Backpressure: m_HREADY low stretches the current address/data phase; m_HRESP ERROR aborts to DONE.
module dmac_channel_engine (
    input  logic        r_HCLK,
    input  logic        r_HRESETn,
    dmac_channel_engine_if.master ahb,
    input  logic        CHANNEL_enable,
    input  logic [11:0] TS,
    input  logic [2:0]  BS,
    input  logic [31:0] DMAC_C0_SrcAddr_Master,
    input  logic [31:0] DMAC_C0_DestAddr_Master,
    input  logic        sync_grant,
    output logic        load_DMAC_C0_Addr,
    output logic        src_addr_inc,
    output logic        dest_addr_inc,
    output logic        src_burst_zero_flag,
    output logic        dest_burst_zero_flag,
    output logic        buffer_zero_flag,
    output logic        buffer_idx_inc,
    output logic        TransferSize_dec_flag,
    output logic        CHANNEL_dis_flag,
    output logic        set_DMACINTR_status
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REQ, S_RD, S_WR, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        incr4_q;
    logic [2:0]  addr_cnt_q;
    logic [2:0]  data_cnt_q;
    logic        dph_q;
    logic [1:0]  idx_q;
    logic        req_entry_q;
    logic [31:0] buffer [0:3];

    logic        xfer;
    logic [2:0]  n_beats;
    logic        addr_active;
    logic        err;
    logic        addr_acc;
    logic        data_done;
    logic        last_data;
    logic        req_incr4;

    // Beat bookkeeping: address and data phases are tracked by separate counters
    // because the data phase of beat k overlaps the address phase of beat k+1.
    assign xfer        = (state_q == S_RD) || (state_q == S_WR);
    assign n_beats     = incr4_q ? 3'd4 : 3'd1;
    assign addr_active = xfer && (addr_cnt_q < n_beats);
    assign err         = xfer && dph_q && (ahb.m_HRESP == 2'b01);
    assign addr_acc    = addr_active && ahb.m_HREADY && !err;
    assign data_done   = xfer && dph_q && ahb.m_HREADY && !err;
    assign last_data   = data_done && (data_cnt_q == (n_beats - 3'd1));
    assign req_incr4   = (BS != 3'd0) && (TS >= 12'd16);

    // Next-state: burst boundaries are the only points where TS and enable are re-examined.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (CHANNEL_enable) state_d = (TS != 12'd0) ? S_LOAD : S_DONE;
            S_LOAD: state_d = S_REQ;
            S_REQ:  if (sync_grant && ahb.m_HREADY) state_d = S_RD;
            S_RD: begin
                if (err)            state_d = S_DONE;
                else if (last_data) state_d = S_WR;
            end
            S_WR: begin
                if (err)                  state_d = S_DONE;
                else if (last_data) begin
                    // TS still holds the pre-decrement value on the final beat.
                    if (TS == 12'd4)          state_d = S_DONE;
                    else if (!CHANNEL_enable) state_d = S_IDLE;
                    else                      state_d = S_REQ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register plus beat counters, data-phase flag and buffer index.
    always_ff @(posedge r_HCLK or negedge r_HRESETn) begin
        if (!r_HRESETn) begin
            state_q     <= S_IDLE;
            incr4_q     <= 1'b0;
            addr_cnt_q  <= 3'd0;
            data_cnt_q  <= 3'd0;
            dph_q       <= 1'b0;
            idx_q       <= 2'd0;
            req_entry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_entry_q <= (state_d == S_REQ) && (state_q != S_REQ);
            if (state_q == S_REQ) incr4_q <= req_incr4;
            if (state_d != state_q) begin
                addr_cnt_q <= 3'd0;
                data_cnt_q <= 3'd0;
                dph_q      <= 1'b0;
            end else begin
                if (addr_acc)      addr_cnt_q <= addr_cnt_q + 3'd1;
                if (data_done)     data_cnt_q <= data_cnt_q + 3'd1;
                if (ahb.m_HREADY)  dph_q      <= addr_acc;
            end
            if (buffer_zero_flag)    idx_q <= 2'd0;
            else if (buffer_idx_inc) idx_q <= idx_q + 2'd1;
        end
    end

    // Buffer capture on each completed read data phase; contents need no reset.
    always_ff @(posedge r_HCLK) begin
        if ((state_q == S_RD) && data_done) buffer[idx_q] <= ahb.m_HRDATA;
    end

    // Bus request drops on the final write data cycle so the arbiter sees a gap between bursts.
    assign ahb.m_HBUSREQ = (state_q == S_REQ) || (xfer && !((state_q == S_WR) && last_data));
    assign ahb.m_HTRANS  = addr_active ? ((addr_cnt_q == 3'd0) ? 2'b10 : 2'b11) : 2'b00;
    assign ahb.m_HADDR   = (state_q == S_RD) ? DMAC_C0_SrcAddr_Master :
                           (state_q == S_WR) ? DMAC_C0_DestAddr_Master : 32'h0;
    assign ahb.m_HWRITE  = (state_q == S_WR);
    assign ahb.m_HSIZE   = 3'b010;
    assign ahb.m_HBURST  = (xfer && incr4_q) ? 3'b011 : 3'b000;
    assign ahb.m_HWDATA  = ((state_q == S_WR) && dph_q) ? buffer[idx_q] : 32'h0;

    assign load_DMAC_C0_Addr     = (state_q == S_LOAD);
    assign src_addr_inc          = (state_q == S_RD) && addr_acc;
    assign dest_addr_inc         = (state_q == S_WR) && addr_acc;
    assign src_burst_zero_flag   = req_entry_q;
    assign dest_burst_zero_flag  = req_entry_q;
    assign buffer_zero_flag      = req_entry_q || ((state_q == S_RD) && last_data);
    assign buffer_idx_inc        = data_done;
    assign TransferSize_dec_flag = (state_q == S_WR) && data_done;
    assign CHANNEL_dis_flag      = (state_q == S_DONE);
    assign set_DMACINTR_status   = (state_q == S_DONE);
endmodule

// File: tb/tb_dmac_channel_engine.sv
// Directed bench: register-bank model, memory-backed AHB slave with stall/error injection.
// Timing: inputs driven on negedge, outputs sampled on negedge or via posedge monitors.
// Slave wait states and error responses are programmed per scenario.
module tb_dmac_channel_engine;
    logic r_HCLK = 1'b0;
    logic r_HRESETn = 1'b0;
    always #5 r_HCLK = ~r_HCLK;

    dmac_channel_engine_if ahb();

    logic        en, gnt = 1'b1;
    logic [11:0] ts;
    logic [2:0]  bs = 3'd0;
    logic [31:0] src_w, dst_w, src_prog = 32'h0, dst_prog = 32'h0;
    logic [11:0] prog_ts = 12'd0;
    logic        prog_go = 1'b0, clr = 1'b0;

    logic load, src_inc, dst_inc, src_bz, dst_bz, buf_z, idx_inc, dec, dis, intr;

    dmac_channel_engine dut (
        .r_HCLK(r_HCLK), .r_HRESETn(r_HRESETn), .ahb(ahb.master),
        .CHANNEL_enable(en), .TS(ts), .BS(bs),
        .DMAC_C0_SrcAddr_Master(src_w), .DMAC_C0_DestAddr_Master(dst_w),
        .sync_grant(gnt),
        .load_DMAC_C0_Addr(load), .src_addr_inc(src_inc), .dest_addr_inc(dst_inc),
        .src_burst_zero_flag(src_bz), .dest_burst_zero_flag(dst_bz),
        .buffer_zero_flag(buf_z), .buffer_idx_inc(idx_inc),
        .TransferSize_dec_flag(dec), .CHANNEL_dis_flag(dis), .set_DMACINTR_status(intr)
    );

    int n_cmp = 0, n_fail = 0;

    // Register bank model.
    always @(posedge r_HCLK or negedge r_HRESETn) begin
        if (!r_HRESETn) begin
            en <= 1'b0; ts <= 12'd0; src_w <= 32'h0; dst_w <= 32'h0;
        end else begin
            if (prog_go) begin
                ts <= prog_ts; en <= 1'b1;
            end else begin
                if (dec) ts <= ts - 12'd4;
                if (dis) en <= 1'b0;
            end
            if (load) begin
                src_w <= src_prog; dst_w <= dst_prog;
            end else begin
                if (src_inc) src_w <= src_w + 32'd4;
                if (dst_inc) dst_w <= dst_w + 32'd4;
            end
        end
    end

    // AHB slave: memory-backed data phases.
    logic [31:0] src_mem [0:1023];
    logic [31:0] dst_mem [0:1023];
    logic        tb_dph, tb_dwr;
    logic [31:0] tb_daddr;
    int          rd_beats, wr_beats;
    logic        hready_r = 1'b1;
    logic [1:0]  hresp_r = 2'b00;
    int          stall_beat = -1, stall_cycles = 0, stalled = 0;
    int          err_beat = -1, err_ph = 0;

    assign ahb.m_HRDATA = (tb_dph && !tb_dwr) ? src_mem[tb_daddr[11:2]] : 32'h0;
    assign ahb.m_HREADY = hready_r;
    assign ahb.m_HRESP  = hresp_r;

    always @(posedge r_HCLK or negedge r_HRESETn) begin
        if (!r_HRESETn) begin
            tb_dph <= 1'b0; tb_dwr <= 1'b0; tb_daddr <= 32'h0; rd_beats <= 0; wr_beats <= 0;
        end else begin
            if (ahb.m_HREADY) begin
                if (tb_dph && ahb.m_HRESP == 2'b00) begin
                    if (tb_dwr) begin
                        dst_mem[tb_daddr[11:2]] <= ahb.m_HWDATA;
                        wr_beats <= wr_beats + 1;
                    end else begin
                        rd_beats <= rd_beats + 1;
                    end
                end
                tb_dph <= ahb.m_HTRANS[1]; tb_dwr <= ahb.m_HWRITE; tb_daddr <= ahb.m_HADDR;
            end
            if (clr) begin rd_beats <= 0; wr_beats <= 0; end
        end
    end

    always @(negedge r_HCLK) begin
        if (clr) begin stalled = 0; err_ph = 0; end
        hready_r = 1'b1; hresp_r = 2'b00;
        if (tb_dph && !tb_dwr && rd_beats == stall_beat && stalled < stall_cycles) begin
            hready_r = 1'b0; stalled++;
        end
        if (tb_dph && tb_dwr && wr_beats == err_beat && err_ph < 2) begin
            hresp_r = 2'b01;
            if (err_ph == 0) hready_r = 1'b0;
            err_ph++;
        end
    end

    // Pulse counters and protocol monitors.
    int src_cnt, dst_cnt, dec_cnt, idx_cnt, load_cnt, dis_cnt, intr_cnt;
    int hold_viol, err_viol, stall_cnt, err_cnt;
    logic [1:0]  trans_q [$];
    logic [2:0]  burst_q [$];
    logic        chk_hold = 1'b0, err_prev = 1'b0;
    logic [31:0] held_addr;
    logic [1:0]  held_trans;

    always @(posedge r_HCLK) begin
        if (clr) begin
            src_cnt <= 0; dst_cnt <= 0; dec_cnt <= 0; idx_cnt <= 0; load_cnt <= 0;
            dis_cnt <= 0; intr_cnt <= 0; hold_viol <= 0; err_viol <= 0;
            stall_cnt <= 0; err_cnt <= 0;
            trans_q.delete(); burst_q.delete();
        end else begin
            if (src_inc) src_cnt <= src_cnt + 1;
            if (dst_inc) dst_cnt <= dst_cnt + 1;
            if (dec)     dec_cnt <= dec_cnt + 1;
            if (idx_inc) idx_cnt <= idx_cnt + 1;
            if (load)    load_cnt <= load_cnt + 1;
            if (dis)     dis_cnt <= dis_cnt + 1;
            if (intr)    intr_cnt <= intr_cnt + 1;
            if (!ahb.m_HREADY) stall_cnt <= stall_cnt + 1;
            if (ahb.m_HRESP == 2'b01) err_cnt <= err_cnt + 1;
            if (ahb.m_HTRANS[1] && ahb.m_HREADY) begin
                trans_q.push_back(ahb.m_HTRANS);
                if (ahb.m_HTRANS == 2'b10) burst_q.push_back(ahb.m_HBURST);
            end
            if (chk_hold && (ahb.m_HADDR !== held_addr || ahb.m_HTRANS !== held_trans))
                hold_viol <= hold_viol + 1;
            if (err_prev && ahb.m_HTRANS !== 2'b00) err_viol <= err_viol + 1;
        end
        chk_hold   <= !ahb.m_HREADY && ahb.m_HRESP == 2'b00 && ahb.m_HTRANS[1];
        held_addr  <= ahb.m_HADDR;
        held_trans <= ahb.m_HTRANS;
        err_prev   <= (ahb.m_HRESP == 2'b01) && !ahb.m_HREADY;
    end

    task automatic clear_counts();
        @(posedge r_HCLK); #2 clr = 1'b1;
        @(posedge r_HCLK); #2 clr = 1'b0;
        @(negedge r_HCLK);
    endtask

    task automatic start_xfer(input logic [11:0] t, input logic [2:0] b, input logic [31:0] s, input logic [31:0] d);
        bs = b; src_prog = s; dst_prog = d; prog_ts = t; prog_go = 1'b1;
        @(negedge r_HCLK);
        prog_go = 1'b0;
    endtask

    task automatic wait_intr(input int max);
        for (int i = 0; i < max && intr_cnt == 0; i++) @(negedge r_HCLK);
        repeat (3) @(negedge r_HCLK);
    endtask

    task automatic test_reset();
        r_HRESETn = 1'b0;
        repeat (3) @(negedge r_HCLK);
        n_cmp++; if (ahb.m_HBUSREQ !== 1'b0) begin n_fail++; $display("FAIL rst_busreq got %0h want 0", ahb.m_HBUSREQ); end
        n_cmp++; if (ahb.m_HTRANS !== 2'b00) begin n_fail++; $display("FAIL rst_htrans got %0h want 0", ahb.m_HTRANS); end
        n_cmp++; if (ahb.m_HADDR !== 32'h0) begin n_fail++; $display("FAIL rst_haddr got %h want 0", ahb.m_HADDR); end
        n_cmp++; if (ahb.m_HSIZE !== 3'b010) begin n_fail++; $display("FAIL rst_hsize got %0h want 2", ahb.m_HSIZE); end
        n_cmp++; if ({load, src_inc, dst_inc, src_bz, dst_bz, buf_z, idx_inc, dec, dis, intr} !== 10'h0) begin
            n_fail++; $display("FAIL rst_pulses got %b want 0", {load, src_inc, dst_inc, src_bz, dst_bz, buf_z, idx_inc, dec, dis, intr}); end
        r_HRESETn = 1'b1;
        clear_counts();
        repeat (3) @(negedge r_HCLK);
        n_cmp++; if (load_cnt !== 0) begin n_fail++; $display("FAIL rst_idle_noload got %0d want 0", load_cnt); end
    endtask

    task automatic test_single();
        src_mem[10'h040] = 32'hA5A5_0001;
        clear_counts();
        start_xfer(12'd4, 3'd0, 32'h100, 32'h200);
        for (int i = 0; i < 10 && load !== 1'b1; i++) @(negedge r_HCLK);
        n_cmp++; if (load !== 1'b1) begin n_fail++; $display("FAIL single_c0_load got %0h want 1", load); end
        @(negedge r_HCLK);
        n_cmp++; if (ahb.m_HBUSREQ !== 1'b1) begin n_fail++; $display("FAIL single_c1_busreq got %0h want 1", ahb.m_HBUSREQ); end
        n_cmp++; if (buf_z !== 1'b1) begin n_fail++; $display("FAIL single_c1_bufzero got %0h want 1", buf_z); end
        @(negedge r_HCLK);
        n_cmp++; if ({ahb.m_HTRANS, ahb.m_HWRITE, ahb.m_HBURST, src_inc} !== {2'b10, 1'b0, 3'b000, 1'b1}) begin
            n_fail++; $display("FAIL single_c2_rdaddr got trans=%0h wr=%0h burst=%0h inc=%0h want 2/0/0/1", ahb.m_HTRANS, ahb.m_HWRITE, ahb.m_HBURST, src_inc); end
        n_cmp++; if (ahb.m_HADDR !== 32'h100) begin n_fail++; $display("FAIL single_c2_haddr got %h want 00000100", ahb.m_HADDR); end
        @(negedge r_HCLK);
        n_cmp++; if ({ahb.m_HTRANS, idx_inc} !== {2'b00, 1'b1}) begin
            n_fail++; $display("FAIL single_c3_rddata got trans=%0h idxinc=%0h want 0/1", ahb.m_HTRANS, idx_inc); end
        @(negedge r_HCLK);
        n_cmp++; if ({ahb.m_HTRANS, ahb.m_HWRITE, dst_inc} !== {2'b10, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL single_c4_wraddr got trans=%0h wr=%0h inc=%0h want 2/1/1", ahb.m_HTRANS, ahb.m_HWRITE, dst_inc); end
        n_cmp++; if (ahb.m_HADDR !== 32'h200) begin n_fail++; $display("FAIL single_c4_haddr got %h want 00000200", ahb.m_HADDR); end
        @(negedge r_HCLK);
        n_cmp++; if (ahb.m_HWDATA !== 32'hA5A5_0001) begin n_fail++; $display("FAIL single_c5_hwdata got %h want a5a50001", ahb.m_HWDATA); end
        n_cmp++; if (dec !== 1'b1) begin n_fail++; $display("FAIL single_c5_dec got %0h want 1", dec); end
        @(negedge r_HCLK);
        n_cmp++; if ({dis, intr} !== 2'b11) begin n_fail++; $display("FAIL single_c6_done got %b want 11", {dis, intr}); end
        repeat (2) @(negedge r_HCLK);
        n_cmp++; if (dst_mem[10'h080] !== 32'hA5A5_0001) begin n_fail++; $display("FAIL single_mem got %h want a5a50001", dst_mem[10'h080]); end
        n_cmp++; if (dec_cnt !== 1) begin n_fail++; $display("FAIL single_dec_cnt got %0d want 1", dec_cnt); end
    endtask

    task automatic test_incr4_two();
        logic [1:0] exp_t;
        clear_counts();
        start_xfer(12'd32, 3'd1, 32'h400, 32'h800);
        wait_intr(200);
        n_cmp++; if (trans_q.size() !== 16) begin n_fail++; $display("FAIL incr4_nbeats got %0d want 16", trans_q.size()); end
        for (int i = 0; i < 4; i++) begin
            exp_t = (i == 0) ? 2'b10 : 2'b11;
            n_cmp++; if (trans_q[i] !== exp_t) begin n_fail++; $display("FAIL incr4_htrans%0d got %0h want %0h", i, trans_q[i], exp_t); end
        end
        n_cmp++; if (src_cnt !== 8) begin n_fail++; $display("FAIL incr4_src_inc got %0d want 8", src_cnt); end
        n_cmp++; if (dst_cnt !== 8) begin n_fail++; $display("FAIL incr4_dst_inc got %0d want 8", dst_cnt); end
        n_cmp++; if (dec_cnt !== 8) begin n_fail++; $display("FAIL incr4_dec got %0d want 8", dec_cnt); end
        n_cmp++; if (intr_cnt !== 1) begin n_fail++; $display("FAIL incr4_intr got %0d want 1", intr_cnt); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (dst_mem[512 + i] !== 32'h1000_0000 + i) begin
                n_fail++; $display("FAIL incr4_mem%0d got %h want %h", i, dst_mem[512 + i], 32'h1000_0000 + i); end
        end
    endtask

    task automatic test_incr4_then_single();
        clear_counts();
        start_xfer(12'd20, 3'd1, 32'h600, 32'hA00);
        wait_intr(200);
        n_cmp++; if (burst_q.size() !== 4) begin n_fail++; $display("FAIL mix_nbursts got %0d want 4", burst_q.size()); end
        n_cmp++; if ({burst_q[0], burst_q[1]} !== {3'b011, 3'b011}) begin n_fail++; $display("FAIL mix_first_burst got %0h/%0h want 3/3", burst_q[0], burst_q[1]); end
        n_cmp++; if ({burst_q[2], burst_q[3]} !== {3'b000, 3'b000}) begin n_fail++; $display("FAIL mix_second_burst got %0h/%0h want 0/0", burst_q[2], burst_q[3]); end
        n_cmp++; if (dec_cnt !== 5) begin n_fail++; $display("FAIL mix_dec got %0d want 5", dec_cnt); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (dst_mem[640 + i] !== 32'h2000_0000 + i) begin
                n_fail++; $display("FAIL mix_mem%0d got %h want %h", i, dst_mem[640 + i], 32'h2000_0000 + i); end
        end
    endtask

    task automatic test_wait_states();
        stall_beat = 1; stall_cycles = 2;
        clear_counts();
        start_xfer(12'd16, 3'd1, 32'h400, 32'hC00);
        wait_intr(200);
        n_cmp++; if (stall_cnt !== 2) begin n_fail++; $display("FAIL ws_stall_cycles got %0d want 2", stall_cnt); end
        n_cmp++; if (hold_viol !== 0) begin n_fail++; $display("FAIL ws_addr_hold got %0d changes want 0", hold_viol); end
        n_cmp++; if ({src_cnt, dst_cnt, dec_cnt, idx_cnt} !== {32'd4, 32'd4, 32'd4, 32'd8}) begin
            n_fail++; $display("FAIL ws_pulses got src=%0d dst=%0d dec=%0d idx=%0d want 4/4/4/8", src_cnt, dst_cnt, dec_cnt, idx_cnt); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (dst_mem[768 + i] !== 32'h1000_0000 + i) begin
                n_fail++; $display("FAIL ws_mem%0d got %h want %h", i, dst_mem[768 + i], 32'h1000_0000 + i); end
        end
        stall_beat = -1; stall_cycles = 0;
    endtask

    task automatic test_error();
        err_beat = 0;
        clear_counts();
        start_xfer(12'd16, 3'd1, 32'h400, 32'hE00);
        wait_intr(200);
        n_cmp++; if (err_cnt !== 2) begin n_fail++; $display("FAIL err_seen got %0d want 2", err_cnt); end
        n_cmp++; if (err_viol !== 0) begin n_fail++; $display("FAIL err_htrans_idle got %0d active want 0", err_viol); end
        n_cmp++; if ({dec_cnt, dst_cnt, src_cnt} !== {32'd0, 32'd1, 32'd4}) begin
            n_fail++; $display("FAIL err_pulses got dec=%0d dst=%0d src=%0d want 0/1/4", dec_cnt, dst_cnt, src_cnt); end
        n_cmp++; if ({dis_cnt, intr_cnt} !== {32'd1, 32'd1}) begin n_fail++; $display("FAIL err_done got dis=%0d intr=%0d want 1/1", dis_cnt, intr_cnt); end
        n_cmp++; if (en !== 1'b0) begin n_fail++; $display("FAIL err_enable got %0h want 0", en); end
        err_beat = -1;
    endtask

    task automatic test_reset_mid();
        clear_counts();
        start_xfer(12'd32, 3'd1, 32'h400, 32'h800);
        for (int i = 0; i < 50 && src_cnt < 2; i++) @(negedge r_HCLK);
        n_cmp++; if (ahb.m_HTRANS !== 2'b11) begin n_fail++; $display("FAIL rmid_beat3 got htrans %0h want 3", ahb.m_HTRANS); end
        r_HRESETn = 1'b0;
        #1;
        n_cmp++; if ({ahb.m_HBUSREQ, ahb.m_HTRANS, ahb.m_HWRITE} !== 4'b0) begin
            n_fail++; $display("FAIL rmid_bus got req=%0h trans=%0h wr=%0h want 0", ahb.m_HBUSREQ, ahb.m_HTRANS, ahb.m_HWRITE); end
        n_cmp++; if ({ahb.m_HADDR, src_inc, idx_inc, buf_z} !== 35'h0) begin
            n_fail++; $display("FAIL rmid_out got addr=%h inc=%0h idx=%0h z=%0h want 0", ahb.m_HADDR, src_inc, idx_inc, buf_z); end
        @(negedge r_HCLK);
        r_HRESETn = 1'b1;
        clear_counts();
        start_xfer(12'd16, 3'd1, 32'h400, 32'h900);
        wait_intr(200);
        n_cmp++; if ({load_cnt, intr_cnt, dec_cnt} !== {32'd1, 32'd1, 32'd4}) begin
            n_fail++; $display("FAIL rmid_restart got load=%0d intr=%0d dec=%0d want 1/1/4", load_cnt, intr_cnt, dec_cnt); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (dst_mem[576 + i] !== 32'h1000_0000 + i) begin
                n_fail++; $display("FAIL rmid_mem%0d got %h want %h", i, dst_mem[576 + i], 32'h1000_0000 + i); end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            src_mem[256 + i] = 32'h1000_0000 + i;
            src_mem[384 + i] = 32'h2000_0000 + i;
        end
        test_reset();
        test_single();
        test_incr4_two();
        test_incr4_then_single();
        test_wait_states();
        test_error();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/dmac_channel_engine.md
# dmac_channel_engine

Single-channel DMA transfer engine: the AHB master side of the DMAC. It consumes the programmed channel state from the DMAC register bank (enable, transfer size, burst size, working source/destination addresses, synchronised grant) and moves data as read-burst into a 4-word buffer, then write-burst out of it. It returns the control pulses the register bank uses to load and advance addresses, decrement the transfer size, clear the channel and raise the interrupt.

## Interface
- BUF_DEPTH, 4, buffer words; equals the INCR4 length; fixed.
- r_HCLK  in  1  clock
- r_HRESETn  in  1  reset; asynchronous, active-low
- CHANNEL_enable  in  1  channel enable from register bank
- TS  in  12  remaining bytes; multiple of 4
- BS  in  3  burst size; 0 = SINGLE, nonzero = INCR4
- DMAC_C0_SrcAddr_Master / DMAC_C0_DestAddr_Master  in  32  working addresses, word-aligned
- sync_grant  in  1  registered HGRANT
- m_HREADY  in  1;  m_HRESP  in  2;  m_HRDATA  in  32
- m_HBUSREQ  out  1  bus request
- m_HADDR  out  32;  m_HTRANS  out  2;  m_HWRITE  out  1;  m_HSIZE  out  3 (always 3'b010);  m_HBURST  out  3 (000 SINGLE / 011 INCR4);  m_HWDATA  out  32
- load_DMAC_C0_Addr  out  1  copy programmed addresses to working addresses
- src_addr_inc / dest_addr_inc  out  1  advance working address by 4
- src_burst_zero_flag / dest_burst_zero_flag  out  1  clear burst counters
- buffer_zero_flag / buffer_idx_inc  out  1  buffer index clear / advance
- TransferSize_dec_flag  out  1  TS -= 4
- CHANNEL_dis_flag  out  1  clear channel enable
- set_DMACINTR_status  out  1  raise transfer interrupt

## Operation
- Reset: state IDLE; all outputs 0; m_HTRANS IDLE (00); buffer index and beat counter 0; buffer contents don't-care.
- IDLE: CHANNEL_enable=1 and TS!=0 -> LOAD. TS=0 with enable -> DONE.
- LOAD (1 cycle): pulse load_DMAC_C0_Addr -> REQ.
- REQ: m_HBUSREQ=1; beats N = 4 if BS!=0 and TS>=16, else 1; pulse buffer_zero_flag, src/dest_burst_zero_flag on entry. sync_grant=1 and m_HREADY=1 -> RD.
- RD: m_HWRITE=0, m_HADDR=SrcAddr_Master; first beat NONSEQ, rest SEQ; m_HBURST per N. Each accepted address phase (HTRANS active and HREADY=1) pulses src_addr_inc the same cycle. Each completed data phase writes m_HRDATA into buffer[idx] and pulses buffer_idx_inc. After last data -> WR, index cleared (buffer_zero_flag).
- WR: same pattern with m_HWRITE=1, m_HADDR=DestAddr_Master, dest_addr_inc per accepted address; m_HWDATA=buffer[idx] during each data phase; each completed write data phase pulses TransferSize_dec_flag and buffer_idx_inc.
- After last write data: TS after decrement 0 -> DONE; CHANNEL_enable=0 -> IDLE (no interrupt); else REQ. m_HBUSREQ drops between bursts for one cycle.
- DONE (1 cycle): pulse CHANNEL_dis_flag and set_DMACINTR_status -> IDLE.
- m_HRESP=ERROR (01) on any data phase: next cycle m_HTRANS=IDLE, remaining beats cancelled, no further inc/dec pulses, -> DONE.
- sync_grant sampled only in REQ; arbiter holds grant for a whole burst.
- CHANNEL_enable sampled only in IDLE and at burst boundaries; a deassertion mid-burst completes the burst.
- Reset mid-transfer returns immediately to reset values; no pulses emitted.

## Timing
- Address/data pipelined per AHB: data phase of beat k overlaps address phase of beat k+1; m_HADDR/HTRANS hold while HREADY=0.
- Inc pulses coincide with the accepting edge, so working address updates at that edge and m_HADDR shows the next address next cycle.
- Zero-wait SINGLE transfer, grant already high: LOAD c0, REQ c1, RD addr c2, RD data c3, WR addr c4, WR data c5, DONE c6.
- Zero-wait INCR4 burst: 4 address cycles + 1 trailing data cycle per direction; 10 cycles REQ-exit to burst end.
- Wait states extend the current phase only; pulse counts unchanged.

## Test plan
- TS=4, BS=0, src 0x100 holds 0xA5A5_0001 -> one SINGLE read then write to dest 0x200 of 0xA5A5_0001; one TS dec; DONE pulses at c6.
- TS=32, BS=1 -> two INCR4 read/write pairs; HTRANS NONSEQ,SEQ,SEQ,SEQ; 8 src_addr_inc, 8 dest_addr_inc, 8 dec pulses; one interrupt.
- TS=20, BS=1 -> one INCR4 pair then one SINGLE pair; m_HBURST 011 then 000.
- HREADY low 2 cycles on read beat 2 -> address/data held, data captured once, same pulse totals.
- HRESP=ERROR on write beat 1 of INCR4 -> HTRANS IDLE next cycle, no further dec, CHANNEL_dis_flag and set_DMACINTR_status pulse once.
- r_HRESETn low during RD beat 3 -> all outputs 0, state IDLE; re-enable restarts from LOAD.
